// File: rtl/bcd_operand_entry.sv
// Operand-entry sequencer for the BCD adder: synchronizes the NEXT button, walks A -> B -> CIN -> result.
// Optional blinking error LED is enabled by defining ERR_BLINK_EN.
module bcd_operand_entry #(
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next_btn_n,
  input  logic [4*DIGITS-1:0] sw_data,
  input  logic                sw_cin,
  output logic                load_A,
  output logic                load_B,
  output logic                load_CIN,
  output logic                load_RSLT,
  output logic [4*DIGITS-1:0] A_out,
  output logic [4*DIGITS-1:0] B_out,
  output logic                CIN_out,
  output logic [2:0]          out_mux_sel,
  output logic                bad_digit,
  output logic                err_led
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CIN  = 2'd2,
    S_RSLT = 2'd3
  } state_t;

  if (BLINK_DIV < 2) begin : g_blink_div_check
    $error("BLINK_DIV must be at least 2");
  end

  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         sync3_q, sync3_d;
  logic         press_q, press_d;
  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         cin_q, cin_d;
  logic         load_a_q, load_a_d;
  logic         load_b_q, load_b_d;
  logic         load_cin_q, load_cin_d;
  logic         load_rslt_q, load_rslt_d;
  logic [2:0]   mux_sel_q, mux_sel_d;
  logic         bad_digit_q, bad_digit_d;
  logic         err_led_q, err_led_d;
  logic         digits_ok;

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sw_data[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  always_comb begin
    sync1_d     = next_btn_n;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    // registered falling edge of the synchronized button: one pulse per press
    press_d     = sync3_q & ~sync2_q;

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    load_cin_d  = 1'b0;
    load_rslt_d = 1'b0;
    bad_digit_d = bad_digit_q;

    if (press_q) begin
      case (state_q)
        S_A: begin
          if (digits_ok) begin
            a_d         = sw_data;
            load_a_d    = 1'b1;
            bad_digit_d = 1'b0;
            state_d     = S_B;
          end else begin
            bad_digit_d = 1'b1;
          end
        end
        S_B: begin
          if (digits_ok) begin
            b_d         = sw_data;
            load_b_d    = 1'b1;
            bad_digit_d = 1'b0;
            state_d     = S_CIN;
          end else begin
            bad_digit_d = 1'b1;
          end
        end
        S_CIN: begin
          cin_d       = sw_cin;
          load_cin_d  = 1'b1;
          load_rslt_d = 1'b1;
          bad_digit_d = 1'b0;
          state_d     = S_RSLT;
        end
        default: begin
          bad_digit_d = 1'b0;
          state_d     = S_A;
        end
      endcase
    end

    mux_sel_d = bad_digit_d ? 3'd4 : {1'b0, state_d};
  end

`ifdef ERR_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt_q, blink_cnt_d;

  // LED starts high on the cycle bad_digit rises, then flips every BLINK_DIV cycles
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    err_led_d   = err_led_q;
    if (!bad_digit_d) begin
      blink_cnt_d = '0;
      err_led_d   = 1'b0;
    end else if (!bad_digit_q) begin
      blink_cnt_d = '0;
      err_led_d   = 1'b1;
    end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      err_led_d   = ~err_led_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_cnt_q <= '0;
    else       blink_cnt_q <= blink_cnt_d;
  end
`else
  always_comb begin
    err_led_d = bad_digit_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync3_q     <= 1'b1;
      press_q     <= 1'b0;
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      load_cin_q  <= 1'b0;
      load_rslt_q <= 1'b0;
      mux_sel_q   <= 3'd0;
      bad_digit_q <= 1'b0;
      err_led_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      press_q     <= press_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      load_cin_q  <= load_cin_d;
      load_rslt_q <= load_rslt_d;
      mux_sel_q   <= mux_sel_d;
      bad_digit_q <= bad_digit_d;
      err_led_q   <= err_led_d;
    end
  end

  assign load_A      = load_a_q;
  assign load_B      = load_b_q;
  assign load_CIN    = load_cin_q;
  assign load_RSLT   = load_rslt_q;
  assign A_out       = a_q;
  assign B_out       = b_q;
  assign CIN_out     = cin_q;
  assign out_mux_sel = mux_sel_q;
  assign bad_digit   = bad_digit_q;
  assign err_led     = err_led_q;

endmodule
